// File: rtl/move_input_ctrl.sv
// ---------------------------------------------------------------------------
// move_input_ctrl
//   Front end of the tic-tac-toe game FSM. Two raw push-buttons are
//   synchronised, debounced and turned into one-cycle press pulses. "next"
//   walks a cursor over the 9 cells. "select" proposes the cursor cell as a
//   move. A selection of an occupied cell is rejected with a timed flash. A
//   legal move is offered to the game FSM as a valid/ready transaction. The
//   player alternates on every accepted move.
//
// Ports
//   clk            system clock
//   rst            asynchronous reset, active low
//   btn_next       raw button, advance cursor (active high)
//   btn_sel        raw button, select cursor cell (active high)
//   occ[8:0]       board occupancy, bit i = cell i taken (sampled in CHECK)
//   new_game       synchronous one-cycle clear from the game FSM
//   move_ready     game FSM accepts the offered move this cycle
//   cursor[3:0]    current cursor cell, 0..8
//   move_valid     move offered to the game FSM
//   move_cell[3:0] cell index of the offered move
//   move_player    0 = player 1, 1 = player 2
//   invalid_flash  high while a rejected selection is signalled
// ---------------------------------------------------------------------------

// Per-button conditioning: 2-FF synchroniser, debouncer, rising-edge pulse.
module move_input_debounce #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          level_d_r;
    logic [CW-1:0] cnt_r;
    logic          level_next_s;
    logic [CW-1:0] cnt_next_s;

    // Debounce rule: count consecutive samples that differ from the level.
    always_comb begin
        level_next_s = level_r;
        cnt_next_s   = cnt_r;
        if (sync2_r == level_r) begin
            cnt_next_s = {CW{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            // This is the DEBOUNCE_CYC-th differing sample: accept it.
            level_next_s = ~level_r;
            cnt_next_s   = {CW{1'b0}};
        end else begin
            cnt_next_s = cnt_r + CNT_ONE;
        end
    end

    // Synchroniser, debounced level and edge-detect history registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            level_r   <= 1'b0;
            level_d_r <= 1'b0;
            cnt_r     <= {CW{1'b0}};
        end else begin
            sync1_r   <= raw;
            sync2_r   <= sync1_r;
            level_r   <= level_next_s;
            level_d_r <= level_r;
            cnt_r     <= cnt_next_s;
        end
    end

    // One-cycle pulse on a 0->1 transition of the debounced level.
    assign pulse = level_r & ~level_d_r;
endmodule

module move_input_ctrl #(
    parameter int DEBOUNCE_CYC = 16,
    parameter int FLASH_CYC    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_sel,
    input  logic [8:0] occ,
    input  logic       new_game,
    input  logic       move_ready,
    output logic [3:0] cursor,
    output logic       move_valid,
    output logic [3:0] move_cell,
    output logic       move_player,
    output logic       invalid_flash
);
    localparam int FCW = $clog2(FLASH_CYC + 1);
    localparam logic [FCW-1:0] FLASH_LAST = FCW'(FLASH_CYC - 1);
    localparam logic [FCW-1:0] FLASH_ONE  = FCW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_REJECT = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic [3:0]     cursor_r;
    logic [3:0]     cursor_next_s;
    logic           valid_r;
    logic           valid_next_s;
    logic [3:0]     cell_r;
    logic [3:0]     cell_next_s;
    logic           player_r;
    logic           player_next_s;
    logic           flash_r;
    logic           flash_next_s;
    logic [FCW-1:0] flash_cnt_r;
    logic [FCW-1:0] flash_cnt_next_s;
    logic           next_pulse_s;
    logic           sel_pulse_s;

    // Cursor advance with wrap from cell 8 back to cell 0.
    function automatic logic [3:0] cursor_inc(input logic [3:0] c);
        if (c >= 4'd8) begin
            return 4'd0;
        end else begin
            return c + 4'd1;
        end
    endfunction

    // Occupancy lookup; an out-of-range index is treated as occupied so a
    // corrupted cell index can never be issued as a move.
    function automatic logic cell_taken(input logic [8:0] o, input logic [3:0] idx);
        if (idx > 4'd8) begin
            return 1'b1;
        end else begin
            return o[idx];
        end
    endfunction

    move_input_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_next (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_next),
        .pulse (next_pulse_s)
    );

    move_input_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_sel (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_sel),
        .pulse (sel_pulse_s)
    );

    // Cursor next value; moves in every FSM state, new_game homes it.
    always_comb begin
        cursor_next_s = cursor_r;
        if (new_game) begin
            cursor_next_s = 4'd0;
        end else if (next_pulse_s) begin
            cursor_next_s = cursor_inc(cursor_r);
        end else begin
            cursor_next_s = cursor_r;
        end
    end

    // FSM next-state and next-output logic.
    always_comb begin
        state_next_s     = state_r;
        valid_next_s     = valid_r;
        cell_next_s      = cell_r;
        player_next_s    = player_r;
        flash_next_s     = flash_r;
        flash_cnt_next_s = flash_cnt_r;
        if (new_game) begin
            // Wins over everything, including a handshake in the same cycle.
            state_next_s     = ST_IDLE;
            valid_next_s     = 1'b0;
            player_next_s    = 1'b0;
            flash_next_s     = 1'b0;
            flash_cnt_next_s = {FCW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    valid_next_s = 1'b0;
                    flash_next_s = 1'b0;
                    if (sel_pulse_s) begin
                        // Registered cursor is the pre-increment value even
                        // when next fires in the same cycle.
                        cell_next_s  = cursor_r;
                        state_next_s = ST_CHECK;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (cell_taken(occ, cell_r)) begin
                        state_next_s     = ST_REJECT;
                        flash_next_s     = 1'b1;
                        flash_cnt_next_s = FLASH_LAST;
                    end else begin
                        state_next_s = ST_ISSUE;
                        valid_next_s = 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (valid_r && move_ready) begin
                        state_next_s  = ST_IDLE;
                        valid_next_s  = 1'b0;
                        player_next_s = ~player_r;
                    end else begin
                        state_next_s = ST_ISSUE;
                        valid_next_s = 1'b1;
                    end
                end
                ST_REJECT: begin
                    if (flash_cnt_r == {FCW{1'b0}}) begin
                        state_next_s = ST_IDLE;
                        flash_next_s = 1'b0;
                    end else begin
                        flash_next_s     = 1'b1;
                        flash_cnt_next_s = flash_cnt_r - FLASH_ONE;
                    end
                end
                default: begin
                    state_next_s     = ST_IDLE;
                    valid_next_s     = 1'b0;
                    flash_next_s     = 1'b0;
                    flash_cnt_next_s = {FCW{1'b0}};
                end
            endcase
        end
    end

    // State and registered output storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cursor_r    <= 4'd0;
            valid_r     <= 1'b0;
            cell_r      <= 4'd0;
            player_r    <= 1'b0;
            flash_r     <= 1'b0;
            flash_cnt_r <= {FCW{1'b0}};
        end else begin
            state_r     <= state_next_s;
            cursor_r    <= cursor_next_s;
            valid_r     <= valid_next_s;
            cell_r      <= cell_next_s;
            player_r    <= player_next_s;
            flash_r     <= flash_next_s;
            flash_cnt_r <= flash_cnt_next_s;
        end
    end

    assign cursor        = cursor_r;
    assign move_valid    = valid_r;
    assign move_cell     = cell_r;
    assign move_player   = player_r;
    assign invalid_flash = flash_r;
endmodule

// File: tb/tb_move_input_ctrl.sv
// ---------------------------------------------------------------------------
// tb_move_input_ctrl
//   Directed scenarios followed by a randomized session of button presses,
//   selections, random occupancy and random ready delays. Expected values
//   come from a transaction-level model: a cursor counter mod 9, a player
//   bit, and the rule "occupied cell -> flash FLASH_CYC cycles, else offer".
// ---------------------------------------------------------------------------
module tb_move_input_ctrl;
    localparam int D = 4;
    localparam int F = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_sel = 1'b0;
    logic [8:0] occ = 9'd0;
    logic       new_game = 1'b0;
    logic       move_ready = 1'b0;
    logic [3:0] cursor;
    logic       move_valid;
    logic [3:0] move_cell;
    logic       move_player;
    logic       invalid_flash;

    int total = 0;
    int bad = 0;
    int cur_m = 0;
    int ply_m = 0;

    move_input_ctrl #(.DEBOUNCE_CYC(D), .FLASH_CYC(F)) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_next      (btn_next),
        .btn_sel       (btn_sel),
        .occ           (occ),
        .new_game      (new_game),
        .move_ready    (move_ready),
        .cursor        (cursor),
        .move_valid    (move_valid),
        .move_cell     (move_cell),
        .move_player   (move_player),
        .invalid_flash (invalid_flash)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Hold one raw button for 'hold' cycles, then leave it released long
    // enough for the debouncer to settle and any flash to finish. Counts the
    // cycles in which flash / valid were seen.
    task automatic press(input bit is_sel, input int hold, output int fl, output int vl);
        fl = 0;
        vl = 0;
        if (is_sel) btn_sel = 1'b1;
        else        btn_next = 1'b1;
        for (int i = 0; i < hold + 16; i++) begin
            if (i == hold) begin
                btn_sel  = 1'b0;
                btn_next = 1'b0;
            end
            tick();
            if (invalid_flash === 1'b1) fl++;
            if (move_valid === 1'b1) vl++;
        end
    endtask

    initial begin
        int fl, vl, dly, op;
        logic [8:0] occ_v;

        // Reset state.
        repeat (3) tick();
        chk("rst_cursor", cursor, 0);
        chk("rst_valid", move_valid, 0);
        chk("rst_cell", move_cell, 0);
        chk("rst_player", move_player, 0);
        chk("rst_flash", invalid_flash, 0);
        rst = 1'b1;
        tick();

        // Glitch shorter than the debounce window.
        press(1'b0, 3, fl, vl);
        chk("glitch_cursor", cursor, 0);

        // Latency: cursor changes on the 2+D+1-th edge after the raw rise.
        btn_next = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t == 2 + D) chk("lat_before", cursor, 0);
            if (t == 2 + D + 1) chk("lat_at", cursor, 1);
        end
        btn_next = 1'b0;
        repeat (16) tick();

        // new_game homes the cursor.
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        chk("ng_cursor", cursor, 0);
        cur_m = 0;

        // Nine presses wrap the cursor.
        for (int i = 1; i <= 9; i++) begin
            press(1'b0, 5, fl, vl);
            cur_m = (cur_m + 1) % 9;
            chk("wrap_cursor", cursor, cur_m);
        end
        for (int i = 0; i < 4; i++) begin
            press(1'b0, 5, fl, vl);
            cur_m = (cur_m + 1) % 9;
        end
        chk("cursor_4", cursor, 4);

        // Legal move with delayed ready.
        occ = 9'd0;
        press(1'b1, 6, fl, vl);
        chk("mv_valid", move_valid, 1);
        chk("mv_cell", move_cell, 4);
        chk("mv_player", move_player, 0);
        chk("mv_noflash", fl, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mv_hold_valid", move_valid, 1);
            chk("mv_hold_cell", move_cell, 4);
            chk("mv_hold_player", move_player, 0);
        end
        move_ready = 1'b1;
        tick();
        move_ready = 1'b0;
        chk("hs_valid_drop", move_valid, 0);
        chk("hs_player", move_player, 1);
        ply_m = 1;

        // Occupied cell is rejected.
        occ = 9'b000010000;
        press(1'b1, 6, fl, vl);
        chk("rej_flash_len", fl, F);
        chk("rej_no_valid", vl, 0);
        chk("rej_player", move_player, ply_m);
        chk("rej_cursor", cursor, 4);

        // Presses during ISSUE: sel dropped, next advances cursor.
        occ = 9'd0;
        press(1'b1, 6, fl, vl);
        chk("iss_valid", move_valid, 1);
        chk("iss_player", move_player, 1);
        press(1'b1, 6, fl, vl);
        chk("iss_sel_cell", move_cell, 4);
        chk("iss_sel_valid", move_valid, 1);
        press(1'b0, 6, fl, vl);
        cur_m = 5;
        chk("iss_next_cursor", cursor, 5);
        chk("iss_next_cell", move_cell, 4);
        move_ready = 1'b1;
        tick();
        move_ready = 1'b0;
        chk("iss_hs_valid", move_valid, 0);
        chk("iss_hs_player", move_player, 0);
        ply_m = 0;

        // new_game overrides a simultaneous handshake.
        press(1'b1, 6, fl, vl);
        chk("ngh_valid_pre", move_valid, 1);
        chk("ngh_cell_pre", move_cell, 5);
        new_game = 1'b1;
        move_ready = 1'b1;
        tick();
        new_game = 1'b0;
        move_ready = 1'b0;
        chk("ngh_valid", move_valid, 0);
        chk("ngh_player", move_player, 0);
        chk("ngh_cursor", cursor, 0);
        chk("ngh_flash", invalid_flash, 0);
        tick();
        chk("ngh_valid_stay", move_valid, 0);
        cur_m = 0;
        ply_m = 0;

        // Asynchronous reset in the middle of ISSUE.
        press(1'b0, 5, fl, vl);
        press(1'b1, 6, fl, vl);
        chk("ar_valid_pre", move_valid, 1);
        chk("ar_cell_pre", move_cell, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid", move_valid, 0);
        chk("ar_cell", move_cell, 0);
        chk("ar_player", move_player, 0);
        chk("ar_cursor", cursor, 0);
        chk("ar_flash", invalid_flash, 0);
        tick();
        rst = 1'b1;
        tick();
        cur_m = 0;
        ply_m = 0;

        // Randomized session against the transaction-level model.
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 2);
            if (op == 0) begin
                press(1'b0, $urandom_range(D, D + 5), fl, vl);
                cur_m = (cur_m + 1) % 9;
                chk("rnd_next_cursor", cursor, cur_m);
            end else if (op == 1) begin
                move_ready = 1'($urandom_range(0, 1));
                press(1'($urandom_range(0, 1)), $urandom_range(1, D - 1), fl, vl);
                move_ready = 1'b0;
                chk("rnd_glitch_cursor", cursor, cur_m);
                chk("rnd_glitch_valid", vl, 0);
            end else begin
                occ_v = 9'($urandom_range(0, 511));
                occ = occ_v;
                press(1'b1, $urandom_range(D, D + 5), fl, vl);
                if (occ_v[cur_m]) begin
                    chk("rnd_rej_flash", fl, F);
                    chk("rnd_rej_valid", vl, 0);
                    chk("rnd_rej_player", move_player, ply_m);
                end else begin
                    chk("rnd_ok_flash", fl, 0);
                    chk("rnd_ok_valid", move_valid, 1);
                    chk("rnd_ok_cell", move_cell, cur_m);
                    chk("rnd_ok_player", move_player, ply_m);
                    occ = 9'($urandom_range(0, 511));
                    dly = $urandom_range(0, 4);
                    for (int k = 0; k < dly; k++) begin
                        tick();
                        chk("rnd_wait_valid", move_valid, 1);
                        chk("rnd_wait_cell", move_cell, cur_m);
                    end
                    move_ready = 1'b1;
                    tick();
                    move_ready = 1'b0;
                    ply_m = ply_m ^ 1;
                    chk("rnd_hs_valid", move_valid, 0);
                    chk("rnd_hs_player", move_player, ply_m);
                end
                chk("rnd_sel_cursor", cursor, cur_m);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/move_input_ctrl.md
Name: move_input_ctrl

Overview:
Upstream front end of the tic-tac-toe game FSM. Synchronises and debounces two raw push-buttons (next, select) and moves a cursor over the 9 board cells. It rejects selections of occupied cells and alternates the player. Each legal move is delivered to the game FSM as a single valid/ready transaction carrying cell index and player.

Parameters:
DEBOUNCE_CYC, 16, consecutive identical synchronised samples required before a debounced level changes (≥2)
FLASH_CYC, 8, cycles invalid_flash stays high after a rejected selection (≥1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
btn_next  input  1  raw async button, advance cursor (active-high)
btn_sel  input  1  raw async button, select cursor cell (active-high)
occ  input  9  board occupancy from game FSM, bit i = cell i taken
new_game  input  1  synchronous one-cycle clear from game FSM (after win/tie/reset)
move_ready  input  1  game FSM accepts move this cycle
cursor  output  4  current cursor cell 0..8
move_valid  output  1  move offered to game FSM
move_cell  output  4  cell index of offered move, 0..8
move_player  output  1  0 = player 1, 1 = player 2
invalid_flash  output  1  high while a rejected selection is being signalled

Behaviour:
- Reset (rst low, async): cursor=0, move_valid=0, move_cell=0, move_player=0, invalid_flash=0, state IDLE, synchronisers/debounced levels/counters=0.
- Input path per button: 2-FF synchroniser -> debouncer -> rising-edge detector.
- Debouncer: counter resets whenever the synchronised sample equals the debounced level. The debounced level flips when the sample has differed for DEBOUNCE_CYC consecutive cycles; the counter then clears. A glitch shorter than DEBOUNCE_CYC produces no change.
- Press pulse: one cycle, on a 0->1 transition of the debounced level. Latency from raw edge to pulse = 2 (sync) + DEBOUNCE_CYC + 1 cycles.
- Cursor: a next-pulse increments the cursor; 8 wraps to 0. The cursor moves in every state, including while a move is pending.
- FSM states: IDLE, CHECK, ISSUE, REJECT.
  - IDLE: a sel-pulse latches cursor into move_cell and goes to CHECK. If next and sel pulse in the same cycle, the pre-increment cursor is latched.
  - CHECK (1 cycle): occ[move_cell]=1 -> REJECT; else -> ISSUE.
  - ISSUE: move_valid=1 from the cycle after CHECK. move_cell and move_player are held stable until the handshake.
    - Handshake = move_valid & move_ready. On the handshake cycle: move_valid drops next cycle, move_player toggles, return to IDLE.
    - move_ready while not in ISSUE is ignored.
  - REJECT: invalid_flash=1 for exactly FLASH_CYC cycles, then IDLE. Player does not toggle.
- Sel-pulses in CHECK/ISSUE/REJECT are dropped, not queued.
- new_game (highest priority, synchronous): next cycle state=IDLE, move_valid=0, invalid_flash=0, move_player=0, cursor=0.
  - Overrides a simultaneous handshake: player resets to 0, not toggled.
  - Pending button pulses in that cycle are discarded.
  - Debouncer state is kept, so a held button does not re-fire.
- occ is sampled only in CHECK; changes at other times have no effect.
- Reset asserted mid-transaction clears everything immediately, including move_valid. No partial move survives.

Test Plan:
- Reset, DEBOUNCE_CYC=4: raw btn_next 3-cycle pulse -> cursor stays 0. 10-cycle pulse -> cursor=1 exactly 2+4+1 cycles after the raw rising edge.
- Press next 9 times from cursor=0 -> cursor sequence 1..8,0 (wrap).
- Cursor=4, occ=0, press sel, move_ready low 5 cycles then high -> move_valid high with move_cell=4, move_player=0 throughout. Drops the cycle after the handshake; move_player=1 afterward.
- occ=9'b000010000, cursor=4, press sel -> no move_valid. invalid_flash high exactly FLASH_CYC=8 cycles; move_player unchanged.
- During ISSUE (ready low): press sel and press next -> no second move, cursor advances, move_cell unchanged.
- In ISSUE, assert new_game together with move_ready -> move_valid=0, move_player=0, cursor=0 next cycle. Separately, drive rst low mid-ISSUE -> all outputs 0 immediately.
